// File: rtl/cic_interpolator_if.sv
// cic_interpolator_if: sample stream, control and status signals of the CIC interpolator
interface cic_interpolator_if #(
    parameter int DATA_WIDTH = 16
);
    logic [4:0]            Interpolation_Factor;
    logic                  filter_enable;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  underrun;

    modport master (
        output Interpolation_Factor, filter_enable, in_valid, data_in,
        input  in_ready, data_out, out_valid, underrun
    );

    modport slave (
        input  Interpolation_Factor, filter_enable, in_valid, data_in,
        output in_ready, data_out, out_valid, underrun
    );
endinterface

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator, runtime factor R in {1,2,4,8,16}, unity DC gain
module cic_interpolator #(
    parameter int DATA_WIDTH = 16,
    parameter int N_STAGES   = 3,
    parameter int ACC_WIDTH  = DATA_WIDTH + 4 * N_STAGES
) (
    input logic CLK,
    input logic RST,
    cic_interpolator_if.slave bus
);
    logic [4:0]                  r_reg, r_new;
    logic [2:0]                  log2r_reg, log2r_new;
    logic [3:0]                  ph;
    logic                        run, flush, und, phase0, boundary, change;
    logic [DATA_WIDTH-1:0]       dout;
    logic signed [ACC_WIDTH-1:0] x, u_reg;
    logic signed [ACC_WIDTH-1:0] c [N_STAGES+1];
    logic signed [ACC_WIDTH-1:0] d [N_STAGES];
    logic signed [ACC_WIDTH-1:0] integ [N_STAGES];

    assign r_new = (bus.Interpolation_Factor != 5'd0 &&
                    (bus.Interpolation_Factor & (bus.Interpolation_Factor - 5'd1)) == 5'd0)
                   ? bus.Interpolation_Factor : 5'd1;
    assign log2r_new = {r_new[4], r_new[3] | r_new[2], r_new[3] | r_new[1]};
    assign phase0   = ph == 4'd0;
    assign boundary = {1'b0, ph} == r_reg - 5'd1;
    assign change   = boundary && r_new != r_reg;
    assign x = bus.in_valid ? {{(ACC_WIDTH-DATA_WIDTH){bus.data_in[DATA_WIDTH-1]}}, bus.data_in} : '0;

    always_comb begin
        c[0] = x;
        for (int k = 0; k < N_STAGES; k++) c[k+1] = c[k] - d[k];
    end

    assign bus.in_ready  = RST && run && bus.filter_enable && phase0 && !flush;
    assign bus.out_valid = RST && run && bus.filter_enable;
    assign bus.data_out  = dout;
    assign bus.underrun  = und;

    // First enabled edge after reset only arms the block; a factor change costs one flush edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_reg     <= r_new;
            log2r_reg <= log2r_new;
            ph        <= '0;
            run       <= 1'b0;
            flush     <= 1'b0;
            und       <= 1'b0;
            dout      <= '0;
            u_reg     <= '0;
            d         <= '{default: '0};
            integ     <= '{default: '0};
        end else if (bus.filter_enable) begin
            if (!run) begin
                run <= 1'b1;
            end else if (flush) begin
                flush <= 1'b0;
            end else if (change) begin
                r_reg     <= r_new;
                log2r_reg <= log2r_new;
                ph        <= '0;
                flush     <= 1'b1;
                dout      <= '0;
                u_reg     <= '0;
                d         <= '{default: '0};
                integ     <= '{default: '0};
            end else begin
                ph <= boundary ? 4'd0 : ph + 4'd1;
                if (phase0) begin
                    und <= und | !bus.in_valid;
                    for (int k = 0; k < N_STAGES; k++) d[k] <= c[k];
                end
                u_reg    <= phase0 ? c[N_STAGES] : '0;
                integ[0] <= integ[0] + u_reg;
                for (int k = 1; k < N_STAGES; k++) integ[k] <= integ[k] + integ[k-1];
                dout <= DATA_WIDTH'(integ[N_STAGES-1] >>> ((N_STAGES - 1) * log2r_reg));
            end
        end
    end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed and random scenarios checked against a convolution model
module tb_cic_interpolator;
    localparam int DW = 16;

    logic CLK_tb = 1'b0;
    logic RST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK_tb = ~CLK_tb;

    cic_interpolator_if #(.DATA_WIDTH(DW)) bus ();
    cic_interpolator #(.DATA_WIDTH(DW), .N_STAGES(3)) dut (.CLK(CLK_tb), .RST(RST), .bus(bus));

    // Model: zero-stuffed input convolved with the (boxcar of length R)^3 response, scaled by R^2.
    int          m_r, m_ph;
    bit          m_run, m_flush, m_und;
    logic [15:0] m_dout;
    longint      hist [64];
    longint      h [64];

    function automatic int decode(logic [4:0] f);
        return (f inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) ? int'(f) : 1;
    endfunction

    function automatic int lg2(int r);
        int s = 0;
        while ((1 << s) < r) s++;
        return s;
    endfunction

    function automatic void set_h(int r);
        for (int i = 0; i < 64; i++) h[i] = 0;
        for (int a = 0; a < r; a++)
            for (int b = 0; b < r; b++)
                for (int e = 0; e < r; e++) h[a+b+e]++;
    endfunction

    function automatic void clear_hist();
        for (int i = 0; i < 64; i++) hist[i] = 0;
    endfunction

    function automatic logic [18:0] expected();
        return {RST && m_run && bus.filter_enable && m_ph == 0 && !m_flush,
                RST && m_run && bus.filter_enable, m_und, m_dout};
    endfunction

    function automatic logic [18:0] observed();
        return {bus.in_ready, bus.out_valid, bus.underrun, bus.data_out};
    endfunction

    task automatic drive(input logic rst, input logic en, input logic [4:0] fac,
                         input logic vld, input logic [15:0] din);
        @(negedge CLK_tb);
        RST = rst;
        bus.filter_enable = en;
        bus.Interpolation_Factor = fac;
        bus.in_valid = vld;
        bus.data_in = din;
        #1;
    endtask

    task automatic tick();
        longint y, v;
        int     rn;
        @(posedge CLK_tb);
        rn = decode(bus.Interpolation_Factor);
        if (!RST) begin
            m_r = rn; set_h(m_r); m_ph = 0; m_run = 0; m_flush = 0; m_und = 0; m_dout = 0;
            clear_hist();
        end else if (bus.filter_enable) begin
            if (!m_run) m_run = 1;
            else if (m_flush) m_flush = 0;
            else if (m_ph == m_r - 1 && rn != m_r) begin
                m_r = rn; set_h(m_r); m_ph = 0; m_flush = 1; m_dout = 0;
                clear_hist();
            end else begin
                v = (m_ph == 0 && bus.in_valid) ? longint'($signed(bus.data_in)) : 0;
                if (m_ph == 0 && !bus.in_valid) m_und = 1;
                for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = v;
                y = 0;
                for (int j = 0; j < 60; j++) y += h[j] * hist[j+4];
                m_dout = 16'(y >>> (2 * lg2(m_r)));
                m_ph = (m_ph + 1) % m_r;
            end
        end
    endtask

    task automatic do_reset(input logic [4:0] fac);
        drive(1'b0, 1'b1, fac, 1'b0, 16'h0);
        tick();
        drive(1'b1, 1'b1, fac, 1'b0, 16'h0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 5'd3, 1'b1, 16'($urandom));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(i == 2, 1'b1, 5'd3, 1'b1, 16'($urandom));
            n_cmp++;
            if (observed() !== 19'h0 || expected() !== 19'h0) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got %h want 0", i, observed());
            end
            tick();
        end
        drive(1'b1, 1'b1, 5'd3, 1'b1, 16'h1234);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_decode: got ready=%b valid=%b want 1 1", bus.in_ready, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_r1_ramp();
        do_reset(5'd1);
        for (int i = 0; i < 105; i++) begin
            drive(1'b1, 1'b1, 5'd1, 1'b1, i < 100 ? 16'(i) : 16'h0);
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL r1_ramp_model cyc %0d: got %h want %h", i, observed(), expected());
            end
            n_cmp++;
            if (bus.data_out !== 16'(i >= 5 ? i - 5 : 0) || bus.in_ready !== 1'b1 || bus.underrun !== 1'b0) begin
                n_bad++;
                $display("FAIL r1_ramp cyc %0d: got out=%h rdy=%b und=%b want out=%h rdy=1 und=0",
                         i, bus.data_out, bus.in_ready, bus.underrun, 16'(i >= 5 ? i - 5 : 0));
            end
            tick();
        end
    endtask

    task automatic test_r2_impulse();
        logic [15:0] want;
        do_reset(5'd2);
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b1, 5'd2, 1'b1, i == 0 ? 16'h1000 : 16'h0);
            want = (i == 5 || i == 8) ? 16'h0400 : (i == 6 || i == 7) ? 16'h0C00 : 16'h0;
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL r2_impulse_model cyc %0d: got %h want %h", i, observed(), expected());
            end
            n_cmp++;
            if (bus.data_out !== want || bus.in_ready !== (i % 2 == 0)) begin
                n_bad++;
                $display("FAIL r2_impulse cyc %0d: got out=%h rdy=%b want out=%h rdy=%b",
                         i, bus.data_out, bus.in_ready, want, i % 2 == 0);
            end
            tick();
        end
    endtask

    task automatic test_r8_constant();
        logic [15:0] vals [2];
        vals[0] = 16'h0100;
        vals[1] = 16'h8000;
        for (int t = 0; t < 2; t++) begin
            do_reset(5'd8);
            for (int i = 0; i < 60; i++) begin
                drive(1'b1, 1'b1, 5'd8, 1'b1, vals[t]);
                n_cmp++;
                if (observed() !== expected()) begin
                    n_bad++;
                    $display("FAIL r8_const_model cyc %0d: got %h want %h", i, observed(), expected());
                end
                if (i >= 28) begin
                    n_cmp++;
                    if (bus.data_out !== vals[t]) begin
                        n_bad++;
                        $display("FAIL r8_const cyc %0d: got %h want %h", i, bus.data_out, vals[t]);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_r16_underrun();
        do_reset(5'd16);
        for (int i = 0; i < 80; i++) begin
            drive(1'b1, 1'b1, 5'd16, i != 32, 16'($urandom));
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL r16_underrun_model cyc %0d: got %h want %h", i, observed(), expected());
            end
            n_cmp++;
            if (bus.underrun !== (i > 32)) begin
                n_bad++;
                $display("FAIL r16_underrun cyc %0d: got %b want %b", i, bus.underrun, i > 32);
            end
            tick();
        end
    endtask

    task automatic test_factor_change();
        logic want_rdy;
        do_reset(5'd8);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, i < 3 ? 5'd8 : 5'd4, 1'b1, 16'($urandom));
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL factor_change_model cyc %0d: got %h want %h", i, observed(), expected());
            end
            want_rdy = i < 8 ? (i % 8 == 0) : i == 8 ? 1'b0 : ((i - 9) % 4 == 0);
            n_cmp++;
            if (bus.in_ready !== want_rdy || (i == 8 && (bus.out_valid !== 1'b1 || bus.data_out !== 16'h0))) begin
                n_bad++;
                $display("FAIL factor_change cyc %0d: got rdy=%b vld=%b out=%h want rdy=%b",
                         i, bus.in_ready, bus.out_valid, bus.data_out, want_rdy);
            end
            tick();
        end
    endtask

    task automatic test_freeze_reset();
        logic        en, rst;
        logic [15:0] frozen;
        do_reset(5'd4);
        frozen = '0;
        for (int i = 0; i < 50; i++) begin
            en  = !(i >= 20 && i < 30);
            rst = i != 42;
            drive(rst, en, 5'd4, 1'b1, 16'($urandom));
            if (i == 20) frozen = m_dout;
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL freeze_model cyc %0d: got %h want %h", i, observed(), expected());
            end
            if (!en) begin
                n_cmp++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.data_out !== frozen) begin
                    n_bad++;
                    $display("FAIL freeze cyc %0d: got rdy=%b vld=%b out=%h want 0 0 %h",
                             i, bus.in_ready, bus.out_valid, bus.data_out, frozen);
                end
            end
            if (i == 42 || i == 43) begin
                n_cmp++;
                if (bus.in_ready !== 1'b0 || (i == 43 && observed() !== 19'h0)) begin
                    n_bad++;
                    $display("FAIL mid_reset cyc %0d: got %h want ready 0", i, observed());
                end
            end
            if (i == 44) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL mid_reset_phase: got rdy=%b want 1", bus.in_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] facs [9];
        logic [4:0] fac;
        facs = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd0, 5'd3, 5'd7, 5'd31};
        do_reset(5'd2);
        fac = 5'd2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) fac = facs[$urandom_range(0, 8)];
            drive($urandom_range(0, 499) != 0, $urandom_range(0, 19) != 0, fac,
                  $urandom_range(0, 15) != 0, 16'($urandom));
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", i, observed(), expected());
            end
            tick();
        end
    endtask

    initial begin
        bus.filter_enable = 1'b0;
        bus.Interpolation_Factor = 5'd1;
        bus.in_valid = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_r1_ramp();
        test_r2_impulse();
        test_r8_constant();
        test_r16_underrun();
        test_factor_change();
        test_freeze_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
